score_ram_arbiter: RTL and testbench
====================================

Name: score_ram_arbiter

Overview:
- Sequences and shares the single-port 16x4 score RAM between two player score requesters (increment or clear) and one display readout requester.
- Runs read-modify-write transactions with saturating increment.
- Arbitrates players round-robin; the display has lowest priority plus an anti-starvation guard.
- Sits between the per-player game logic and the score RAM, in place of direct RAM access.

Parameters:
- AW, 4, RAM address width (entry index = internal id).
- DW, 4, score data width.
- SAT_MAX, 15, saturation value for increments; must be at most 2^DW-1.
- DISP_AGE, 3, consecutive lost arbitrations after which a pending display request wins.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- p0_req  input  1  player 0 request; held until p0_ack
- p0_id  input  AW  player 0 target entry
- p0_clr  input  1  1 = clear entry to 0, 0 = increment entry
- p0_ack  output  1  one-cycle pulse, player 0 transaction committed
- p1_req, p1_id, p1_clr, p1_ack  same as player 0, for player 1
- disp_req  input  1  display read request; held until disp_valid
- disp_id  input  AW  entry to read
- disp_valid  output  1  one-cycle pulse, disp_data valid
- disp_data  output  DW  score read for the display; holds its value until the next display read
- ram_address  output  AW  to RAM address (RAM registers address, q valid the cycle after capture)
- ram_data  output  DW  to RAM write data
- ram_wren  output  1  to RAM write enable
- ram_q  input  DW  from RAM read data
- busy  output  1  FSM not in IDLE
- max_score  output  DW  see Optional Feature

Behaviour:
- Reset values:
  - state IDLE
  - all ack/valid outputs 0
  - ram_wren 0, ram_address 0, ram_data 0, disp_data 0, max_score 0
  - rr pointer favours p0, display age counter 0
- FSM states: IDLE, RD, WT, WR, DOUT.
- IDLE arbitration, one decision per cycle, registered:
  - Display wins when disp_req=1 and either no player request is pending or age counter >= DISP_AGE.
  - Otherwise the players are granted round-robin; if only one requests, it is granted.
  - The rr pointer flips to the non-granted player after each player grant.
  - The age counter increments each IDLE cycle in which disp_req=1 and a player wins. It clears on a display grant. It saturates at DISP_AGE.
- Granted id and clr are latched at the grant; later input changes are ignored until ack.
- Increment path: IDLE (grant, ram_address <= id) -> RD -> WT (ram_q valid; compute) -> WR.
  - In WR: ram_wren=1, ram_data = (q == SAT_MAX) ? SAT_MAX : q+1.
  - Ack pulses in the WR cycle; the FSM returns to IDLE next cycle.
  - Grant-to-ack latency = 3 cycles.
- Clear path: IDLE -> WR directly; ram_data=0, ram_wren=1, ack in WR. Latency = 1 cycle.
- Display path: IDLE -> RD -> WT -> DOUT.
  - disp_data <= ram_q at the end of WT; disp_valid=1 in DOUT; then IDLE.
  - The display path never asserts ram_wren.
- ram_wren is high only in WR. ram_address is stable from the grant through WR.
- Deasserting a request before its ack is a protocol violation: the transaction still completes and the ack still pulses.
- Minimum spacing between transactions is one IDLE cycle, so back-to-back requests from the same player to the same id see the previously written value.
- p0 and p1 targeting the same id are serialised; both increments land (no lost update).
- Reset asserted in any state:
  - Next cycle is IDLE with ram_wren=0.
  - No ack or valid is issued for the aborted transaction; a partial RMW performs no write.

Optional Feature:
- Macro SCORE_MAX_TRACK_EN.
- Defined: max_score is a register that, on every WR with ram_data > max_score, loads ram_data. Clears leave it unchanged. Reset clears it to 0.
- Undefined: max_score is tied to 0 and no comparator is synthesised.

Test Plan:
- Reset, then p0_req id=5 clr=0 with RAM[5]=3 -> ram_wren high exactly 3 cycles after grant, ram_data=4, p0_ack one pulse, RAM[5]=4.
- RAM[2]=15, p1 increment id=2 -> written value 15 (saturation); ack still pulses.
- p0 and p1 request increment of id=7 (RAM[7]=0) in the same cycle -> p0 served first, then p1; final RAM[7]=2; acks in order p0, p1.
- Both players request continuously while disp_req=1 id=4 (RAM[4]=9) -> display granted after 3 lost arbitrations; disp_valid pulse with disp_data=9; ram_wren never high during the display transaction.
- Reset asserted during WT of an increment of id=1 -> no ram_wren, no p0_ack, state IDLE; RAM[1] unchanged.
- With SCORE_MAX_TRACK_EN: increments writing 4, then 9, then clear id, then 6 -> max_score 4, 9, 9, 9. Without the macro -> max_score stays 0 throughout.

Source files
------------

// File: rtl/score_ram_arbiter.sv
// Shares the single-port score RAM between two round-robin players (saturating increment / clear) and a display reader.
// Grant->ack is 3 cycles for increment and 1 for clear, 3 to disp_valid; requests are held until ack/valid. Optional max_score tracking: SCORE_MAX_TRACK_EN.
module score_ram_arbiter #(
   parameter int AW       = 4,
   parameter int DW       = 4,
   parameter int SAT_MAX  = 15,
   parameter int DISP_AGE = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          p0_req,
   input  logic [AW-1:0] p0_id,
   input  logic          p0_clr,
   output logic          p0_ack,
   input  logic          p1_req,
   input  logic [AW-1:0] p1_id,
   input  logic          p1_clr,
   output logic          p1_ack,
   input  logic          disp_req,
   input  logic [AW-1:0] disp_id,
   output logic          disp_valid,
   output logic [DW-1:0] disp_data,
   output logic [AW-1:0] ram_address,
   output logic [DW-1:0] ram_data,
   output logic          ram_wren,
   input  logic [DW-1:0] ram_q,
   output logic          busy,
   output logic [DW-1:0] max_score
);

   localparam int AGE_W = $clog2(DISP_AGE + 1);

   typedef enum logic [2:0] {IDLE, RD, WT, WR, DOUT} state_t;
   typedef enum logic [1:0] {OWN_P0, OWN_P1, OWN_DISP} owner_t;

   state_t           state, state_nxt;
   owner_t           owner;
   logic             rr;
   logic [AGE_W-1:0] age;
   logic             age_full;
   logic             grant_p0, grant_p1, grant_disp, grant_any;
   logic [DW-1:0]    inc_val;

   assign age_full  = (age >= AGE_W'(DISP_AGE));
   assign grant_any = grant_p0 | grant_p1 | grant_disp;
   assign inc_val   = (ram_q == DW'(SAT_MAX)) ? DW'(SAT_MAX) : ram_q + DW'(1);

   // Display only overtakes players once it has lost DISP_AGE decisions in a row.
   always_comb begin
      grant_p0   = 1'b0;
      grant_p1   = 1'b0;
      grant_disp = 1'b0;
      if (state == IDLE) begin
         if (disp_req && (!(p0_req || p1_req) || age_full))
            grant_disp = 1'b1;
         else if (p0_req && (!p1_req || !rr))
            grant_p0 = 1'b1;
         else if (p1_req)
            grant_p1 = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_disp)    state_nxt = RD;
            else if (grant_p0) state_nxt = p0_clr ? WR : RD;
            else if (grant_p1) state_nxt = p1_clr ? WR : RD;
         end
         RD:      state_nxt = WT;
         WT:      state_nxt = (owner == OWN_DISP) ? DOUT : WR;
         WR:      state_nxt = IDLE;
         DOUT:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ram_wren   = (state == WR);
      p0_ack     = (state == WR) && (owner == OWN_P0);
      p1_ack     = (state == WR) && (owner == OWN_P1);
      disp_valid = (state == DOUT);
      busy       = (state != IDLE);
   end

   // Address, owner and write data are captured at grant so requester inputs may change freely afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner       <= OWN_P0;
         rr          <= 1'b0;
         age         <= '0;
         ram_address <= '0;
         ram_data    <= '0;
         disp_data   <= '0;
      end else begin
         if (grant_disp) begin
            owner       <= OWN_DISP;
            ram_address <= disp_id;
            age         <= '0;
         end else if (grant_p0) begin
            owner       <= OWN_P0;
            ram_address <= p0_id;
            rr          <= 1'b1;
            if (p0_clr) ram_data <= '0;
         end else if (grant_p1) begin
            owner       <= OWN_P1;
            ram_address <= p1_id;
            rr          <= 1'b0;
            if (p1_clr) ram_data <= '0;
         end
         if (grant_any && !grant_disp && disp_req && !age_full)
            age <= age + AGE_W'(1);
         if (state == WT) begin
            if (owner == OWN_DISP) disp_data <= ram_q;
            else                   ram_data  <= inc_val;
         end
      end
   end

`ifdef SCORE_MAX_TRACK_EN
   always_ff @(posedge clk) begin
      if (reset)
         max_score <= '0;
      else if ((state == WR) && (ram_data > max_score))
         max_score <= ram_data;
   end
`else
   assign max_score = '0;
`endif

endmodule

// File: tb/tb_score_ram_arbiter.sv
// Directed bench for score_ram_arbiter with a registered-address RAM model.
module tb_score_ram_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       p0_req, p0_clr, p0_ack;
   logic [3:0] p0_id;
   logic       p1_req, p1_clr, p1_ack;
   logic [3:0] p1_id;
   logic       disp_req, disp_valid;
   logic [3:0] disp_id, disp_data;
   logic [3:0] ram_address, ram_data, ram_q, max_score;
   logic       ram_wren, busy;

   logic [3:0] mem [16];
   logic       pre_en;
   logic [3:0] pre_addr, pre_val;

   int n_chk  = 0;
   int n_fail = 0;

`ifdef SCORE_MAX_TRACK_EN
   localparam bit TRK = 1'b1;
`else
   localparam bit TRK = 1'b0;
`endif

   always #5 clk = ~clk;

   score_ram_arbiter dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_id(p0_id), .p0_clr(p0_clr), .p0_ack(p0_ack),
      .p1_req(p1_req), .p1_id(p1_id), .p1_clr(p1_clr), .p1_ack(p1_ack),
      .disp_req(disp_req), .disp_id(disp_id), .disp_valid(disp_valid), .disp_data(disp_data),
      .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
      .busy(busy), .max_score(max_score)
   );

   always @(posedge clk) begin
      if (pre_en)        mem[pre_addr] <= pre_val;
      else if (ram_wren) mem[ram_address] <= ram_data;
      ram_q <= mem[ram_address];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic preload(input logic [3:0] a, input logic [3:0] v);
      pre_en = 1'b1; pre_addr = a; pre_val = v;
      tick();
      pre_en = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Issues one player request, returns ack latency, write count, last write cycle/data/address.
   task automatic player_txn(input int p, input logic [3:0] id, input logic clr,
                             output int lat, output int wcnt, output int wcyc,
                             output logic [3:0] wdata, output logic [3:0] waddr);
      bit done = 0;
      lat = 0; wcnt = 0; wcyc = 0; wdata = 'x; waddr = 'x;
      if (p == 0) begin p0_req = 1'b1; p0_id = id; p0_clr = clr; end
      else        begin p1_req = 1'b1; p1_id = id; p1_clr = clr; end
      for (int c = 1; c <= 20 && !done; c++) begin
         tick();
         if (ram_wren) begin wcnt++; wcyc = c; wdata = ram_data; waddr = ram_address; end
         if ((p == 0) ? p0_ack : p1_ack) begin lat = c; done = 1; end
      end
      p0_req = 1'b0; p1_req = 1'b0;
      if (!done) chk("txn_timeout", 0, 1);
      tick();
      chk("ack_single", (p == 0) ? p0_ack : p1_ack, 0);
   endtask

   initial begin
      int lat, wcnt, wcyc, cnt, acks, dcyc, wr_disp, a0c, a1c;
      logic [3:0] wdata, waddr, ddata;
      bit after3;
      reset = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_val = '0;
      p0_req = 0; p0_id = '0; p0_clr = 0; p1_req = 0; p1_id = '0; p1_clr = 0;
      disp_req = 0; disp_id = '0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         preload(4'(i), 4'd0);
      end
      do_reset();

      chk("rst_busy", busy, 0);
      chk("rst_wren", ram_wren, 0);
      chk("rst_addr", ram_address, 0);
      chk("rst_data", ram_data, 0);
      chk("rst_disp_data", disp_data, 0);
      chk("rst_acks", {p0_ack, p1_ack, disp_valid}, 0);
      chk("rst_max", max_score, 0);

      // Increment id 5 from 3.
      preload(4'd5, 4'd3);
      player_txn(0, 4'd5, 1'b0, lat, wcnt, wcyc, wdata, waddr);
      chk("inc_lat", lat, 3);
      chk("inc_wcnt", wcnt, 1);
      chk("inc_wcyc", wcyc, 3);
      chk("inc_wdata", wdata, 4);
      chk("inc_waddr", waddr, 5);
      chk("inc_mem5", mem[5], 4);

      // Saturation at 15 via player 1.
      preload(4'd2, 4'd15);
      player_txn(1, 4'd2, 1'b0, lat, wcnt, wcyc, wdata, waddr);
      chk("sat_lat", lat, 3);
      chk("sat_wdata", wdata, 15);
      chk("sat_mem2", mem[2], 15);

      // Clear path.
      player_txn(0, 4'd5, 1'b1, lat, wcnt, wcyc, wdata, waddr);
      chk("clr_lat", lat, 1);
      chk("clr_wdata", wdata, 0);
      chk("clr_mem5", mem[5], 0);

      // Both players increment id 7 together.
      do_reset();
      preload(4'd7, 4'd0);
      p0_req = 1; p0_id = 4'd7; p0_clr = 0;
      p1_req = 1; p1_id = 4'd7; p1_clr = 0;
      a0c = 0; a1c = 0;
      for (int c = 1; c <= 30 && (a0c == 0 || a1c == 0); c++) begin
         tick();
         if (p0_ack) begin a0c = c; p0_req = 0; end
         if (p1_ack) begin a1c = c; p1_req = 0; end
      end
      p0_req = 0; p1_req = 0;
      tick();
      chk("same_p0_ack_cyc", a0c, 3);
      chk("same_p1_ack_cyc", a1c, 7);
      chk("same_mem7", mem[7], 2);

      // Display ages out after three lost decisions.
      do_reset();
      preload(4'd4, 4'd9);
      preload(4'd10, 4'd0);
      preload(4'd11, 4'd0);
      disp_req = 1; disp_id = 4'd4;
      p0_req = 1; p0_id = 4'd10; p0_clr = 0;
      p1_req = 1; p1_id = 4'd11; p1_clr = 0;
      acks = 0; dcyc = 0; wr_disp = 0; after3 = 0; ddata = 'x;
      for (int c = 1; c <= 40 && dcyc == 0; c++) begin
         tick();
         if (after3 && ram_wren) wr_disp++;
         if (p0_ack || p1_ack) acks++;
         if (acks == 3) after3 = 1;
         if (disp_valid) begin dcyc = c; ddata = disp_data; end
      end
      disp_req = 0; p0_req = 0; p1_req = 0;
      chk("disp_cyc", dcyc, 15);
      chk("disp_player_acks", acks, 3);
      chk("disp_data", ddata, 9);
      chk("disp_no_wren", wr_disp, 0);
      tick();
      chk("disp_valid_pulse", disp_valid, 0);
      chk("disp_data_hold", disp_data, 9);
      chk("disp_idle", busy, 0);
      chk("disp_mem10", mem[10], 2);

      // Reset in WT of an increment of id 1.
      preload(4'd1, 4'd6);
      p0_req = 1; p0_id = 4'd1; p0_clr = 0;
      tick();
      tick();
      chk("abort_busy_wt", busy, 1);
      reset = 1; p0_req = 0;
      tick();
      chk("abort_wren", ram_wren, 0);
      chk("abort_ack", p0_ack, 0);
      chk("abort_busy", busy, 0);
      reset = 0;
      cnt = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (ram_wren || p0_ack) cnt++;
      end
      chk("abort_quiet", cnt, 0);
      chk("abort_mem1", mem[1], 6);

      // max_score tracking: 4, 9, clear, 6.
      do_reset();
      preload(4'd8, 4'd3);
      player_txn(0, 4'd8, 1'b0, lat, wcnt, wcyc, wdata, waddr);
      chk("max_after4", max_score, TRK ? 4 : 0);
      preload(4'd9, 4'd8);
      player_txn(1, 4'd9, 1'b0, lat, wcnt, wcyc, wdata, waddr);
      chk("max_after9", max_score, TRK ? 9 : 0);
      player_txn(0, 4'd9, 1'b1, lat, wcnt, wcyc, wdata, waddr);
      chk("max_after_clr", max_score, TRK ? 9 : 0);
      preload(4'd10, 4'd5);
      player_txn(1, 4'd10, 1'b0, lat, wcnt, wcyc, wdata, waddr);
      chk("max_after6", max_score, TRK ? 9 : 0);
      chk("max_mem10", mem[10], 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
